led_frame_scheduler: RTL and testbench

- Double-buffered frame controller that sits between the game logic and the 16x16x2 LED display driver.
- Drives the driver's EnableCount, RedPixels and GrnPixels inputs from a front buffer.
- Accepts pixel writes and clear commands into a back buffer, and swaps the two buffers only at a frame boundary, so the display never shows a half-drawn frame.

---
 rtl/led_pkg.sv | 22 ++
 rtl/led_frame_timer.sv | 49 ++++
 rtl/led_frame_scheduler.sv | 154 +++++++++++++++
 tb/tb_led_frame_scheduler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and constants for the LED frame scheduler.
//   ROWS/COLS      : display geometry (16 x 16)
//   plane_t        : one colour plane, indexed [row][col]
//   sched_state_t  : scheduler FSM states
//   COLOR_*_BIT    : bit positions inside wr_color
package led_pkg;

   localparam int ROWS = 16;
   localparam int COLS = 16;

   typedef logic [ROWS-1:0][COLS-1:0] plane_t;

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      SWAP_WAIT
   } sched_state_t;

   localparam int COLOR_RED_BIT = 0;
   localparam int COLOR_GRN_BIT = 1;

endpackage

// File: rtl/led_frame_timer.sv
// Scan timing for the LED frame scheduler.
// Registers the scan request onto enable_count, runs the frame counter that
// mirrors the display driver's row counter, and flags the frame boundary.
// Optional build macro LED_DIM_EN adds a 3-bit PWM counter for dimming.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   run            : scan enable request
//   pwm            : PWM phase (LED_DIM_EN builds only)
//   enable_count   : registered run, drives the display driver
//   frame_tick     : high on the last enabled cycle of a frame
module led_frame_timer #(
   parameter int FREQDIV = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
`ifdef LED_DIM_EN
   output logic [2:0] pwm,
`endif
   output logic       enable_count,
   output logic       frame_tick
);

   // 4 extra bits: 16 rows of 2^FREQDIV enabled cycles each.
   logic [FREQDIV+3:0] fcnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enable_count <= 1'b0;
         fcnt         <= '0;
      end else begin
         enable_count <= run;
         if (enable_count)
            fcnt <= fcnt + 1'b1;   // wraps to 0 on the frame_tick cycle
      end
   end

   assign frame_tick = enable_count & (&fcnt);

`ifdef LED_DIM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pwm <= 3'd0;
      else if (enable_count)
         pwm <= pwm + 3'd1;
   end
`endif

endmodule

// File: rtl/led_frame_scheduler.sv
// Double-buffered frame controller in front of the 16x16x2 LED driver.
// The front buffer drives RedPixels/GrnPixels; writes and clears go to the
// back buffer; the buffers swap only at a frame boundary (or immediately
// when scanning is halted).
// Optional build macro LED_DIM_EN adds the 3-bit 'dim' input, blanking the
// pixel outputs for part of each 8-step PWM period (duty (dim+1)/8).
// The display driver must share RST_N so the row counters stay aligned.
// Ports:
//   CLK, RST_N            : clock, asynchronous active-low reset
//   run                   : scan enable request
//   dim                   : brightness 0..7 (LED_DIM_EN builds only)
//   EnableCount           : scan enable to the driver
//   RedPixels, GrnPixels  : front-buffer planes [row][col]
//   wr_valid/wr_ready     : pixel write handshake; wr_y, wr_x, wr_color
//   clr_req, swap_req     : single-cycle command pulses
//   busy                  : FSM not IDLE
//   swap_done             : high on the cycle the swap takes effect
//   frame_tick            : high on the frame boundary cycle
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | accepting pixel writes and commands
// CLEAR     | zeroing one back-buffer row per cycle, rows 0..15
// SWAP_WAIT | waiting for the frame boundary (or halted scan) to swap
module led_frame_scheduler
   import led_pkg::*;
#(
   parameter int FREQDIV = 15
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                run,
`ifdef LED_DIM_EN
   input  logic [2:0]          dim,
`endif
   output logic                EnableCount,
   output logic [15:0][15:0]   RedPixels,
   output logic [15:0][15:0]   GrnPixels,
   input  logic                wr_valid,
   output logic                wr_ready,
   input  logic [3:0]          wr_y,
   input  logic [3:0]          wr_x,
   input  logic [1:0]          wr_color,
   input  logic                clr_req,
   input  logic                swap_req,
   output logic                busy,
   output logic                swap_done,
   output logic                frame_tick
);

   sched_state_t state;
   logic         sel;
   logic         swap_pend;
   logic         armed;
   logic [3:0]   clr_row;
   plane_t       red_buf [2];
   plane_t       grn_buf [2];
   logic         back;
   logic         wr_fire;
   logic         swap_now;
   plane_t       front_red;
   plane_t       front_grn;

`ifdef LED_DIM_EN
   logic [2:0]   pwm;
   logic         blank;
`endif

   led_frame_timer #(
      .FREQDIV(FREQDIV)
   ) u_timer (
      .clk          (CLK),
      .rst_n        (RST_N),
      .run          (run),
`ifdef LED_DIM_EN
      .pwm          (pwm),
`endif
      .enable_count (EnableCount),
      .frame_tick   (frame_tick)
   );

   assign back = ~sel;

   // armed keeps wr_ready low while reset is held and for the first edge after.
   assign wr_ready = armed & (state == IDLE) & ~clr_req;
   assign wr_fire  = wr_valid & wr_ready;
   assign busy     = (state != IDLE);

   // A halted scan never produces frame_tick, so swap straight away then.
   assign swap_now  = (state == SWAP_WAIT) & (frame_tick | ~EnableCount);
   assign swap_done = swap_now;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= IDLE;
         sel       <= 1'b0;
         swap_pend <= 1'b0;
         armed     <= 1'b0;
         clr_row   <= 4'd0;
         for (int i = 0; i < 2; i++) begin
            red_buf[i] <= '0;
            grn_buf[i] <= '0;
         end
      end else begin
         armed <= 1'b1;
         case (state)
            IDLE: begin
               if (wr_fire) begin
                  red_buf[back][wr_y][wr_x] <= wr_color[COLOR_RED_BIT];
                  grn_buf[back][wr_y][wr_x] <= wr_color[COLOR_GRN_BIT];
               end
               if (clr_req) begin
                  state     <= CLEAR;
                  clr_row   <= 4'd0;
                  swap_pend <= swap_req;   // keep a coincident swap request
               end else if (swap_req) begin
                  state <= SWAP_WAIT;
               end
            end
            CLEAR: begin
               red_buf[back][clr_row] <= '0;
               grn_buf[back][clr_row] <= '0;
               clr_row <= clr_row + 4'd1;
               if (swap_req)
                  swap_pend <= 1'b1;
               if (clr_row == 4'd15) begin
                  state     <= (swap_pend | swap_req) ? SWAP_WAIT : IDLE;
                  swap_pend <= 1'b0;
               end
            end
            SWAP_WAIT: begin
               if (swap_now) begin
                  sel   <= ~sel;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign front_red = red_buf[sel];
   assign front_grn = grn_buf[sel];

`ifdef LED_DIM_EN
   assign blank     = (pwm > dim);
   assign RedPixels = blank ? '0 : front_red;
   assign GrnPixels = blank ? '0 : front_grn;
`else
   assign RedPixels = front_red;
   assign GrnPixels = front_grn;
`endif

endmodule

// File: tb/tb_led_frame_scheduler.sv
module tb_led_frame_scheduler;

   logic              CLK      = 1'b0;
   logic              RST_N    = 1'b1;
   logic              run      = 1'b0;
   logic              wr_valid = 1'b0;
   logic [3:0]        wr_y     = 4'd0;
   logic [3:0]        wr_x     = 4'd0;
   logic [1:0]        wr_color = 2'd0;
   logic              clr_req  = 1'b0;
   logic              swap_req = 1'b0;
   logic              EnableCount, wr_ready, busy, swap_done, frame_tick;
   logic [15:0][15:0] RedPixels, GrnPixels;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   led_frame_scheduler #(.FREQDIV(2)) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .run        (run),
      .EnableCount(EnableCount),
      .RedPixels  (RedPixels),
      .GrnPixels  (GrnPixels),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_y       (wr_y),
      .wr_x       (wr_x),
      .wr_color   (wr_color),
      .clr_req    (clr_req),
      .swap_req   (swap_req),
      .busy       (busy),
      .swap_done  (swap_done),
      .frame_tick (frame_tick)
   );

   // Advances cycle by cycle (sampling 1 time unit after each falling edge)
   // until frame_tick is seen or the budget runs out.
   task automatic wait_tick(output bit found, output bit pre_sd, output bit pre_pix);
      found = 1'b0; pre_sd = 1'b0; pre_pix = 1'b0;
      for (int i = 0; i < 200; i++) begin
         #1;
         if (frame_tick === 1'b1) begin
            found = 1'b1;
            break;
         end
         if (swap_done === 1'b1) pre_sd = 1'b1;
         if (RedPixels[2][3] === 1'b1) pre_pix = 1'b1;
         @(negedge CLK);
      end
   endtask

   task automatic write_px(input logic [3:0] y, input logic [3:0] x, input logic [1:0] c);
      @(negedge CLK);
      wr_valid = 1'b1; wr_y = y; wr_x = x; wr_color = c;
      @(negedge CLK);
      wr_valid = 1'b0;
   endtask

   task automatic test_reset;
      #1 RST_N = 1'b0;
      repeat (2) @(negedge CLK);
      #1;
      total++; if (EnableCount !== 1'b0) begin bad++; $display("FAIL reset_enable got=%b want=0", EnableCount); end
      total++; if (RedPixels !== '0 || GrnPixels !== '0) begin bad++; $display("FAIL reset_pixels got=%h/%h want=0", RedPixels, GrnPixels); end
      total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL reset_wr_ready got=%b want=0", wr_ready); end
      total++; if (busy !== 1'b0 || swap_done !== 1'b0 || frame_tick !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b%b want=000", busy, swap_done, frame_tick); end
      RST_N = 1'b1;
      @(negedge CLK); #1;
      total++; if (wr_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL post_reset_idle got ready=%b busy=%b want 1/0", wr_ready, busy); end
   endtask

   task automatic test_scan;
      int tick_err;
      int pix_err;
      bit exp_tick;
      tick_err = 0; pix_err = 0;
      @(negedge CLK);
      run = 1'b1;
      #1;
      total++; if (EnableCount !== 1'b0) begin bad++; $display("FAIL scan_latency got=%b want=0", EnableCount); end
      for (int i = 1; i <= 128; i++) begin
         @(negedge CLK); #1;
         if (i == 1) begin
            total++; if (EnableCount !== 1'b1) begin bad++; $display("FAIL scan_enable got=%b want=1", EnableCount); end
         end
         exp_tick = (i == 64) || (i == 128);
         if (frame_tick !== exp_tick) begin
            tick_err++;
            $display("FAIL scan_tick cycle=%0d got=%b want=%b", i, frame_tick, exp_tick);
         end
         if (RedPixels !== '0 || GrnPixels !== '0) pix_err++;
      end
      total++; if (tick_err != 0) begin bad++; $display("FAIL scan_tick_period got=%0d wrong cycles want=0", tick_err); end
      total++; if (pix_err != 0) begin bad++; $display("FAIL scan_pixels got=%0d nonzero cycles want=0", pix_err); end
   endtask

   task automatic test_write_swap;
      bit found, pre_sd, pre_pix;
      @(negedge CLK);
      wr_valid = 1'b1; wr_y = 4'd2; wr_x = 4'd3; wr_color = 2'd3;
      #1;
      total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL ws_wr_ready got=%b want=1", wr_ready); end
      @(negedge CLK);
      wr_valid = 1'b0; swap_req = 1'b1;
      #1;
      total++; if (RedPixels[2][3] !== 1'b0) begin bad++; $display("FAIL ws_front_untouched got=%b want=0", RedPixels[2][3]); end
      @(negedge CLK);
      swap_req = 1'b0;
      #1;
      total++; if (busy !== 1'b1 || wr_ready !== 1'b0) begin bad++; $display("FAIL ws_swap_wait got busy=%b ready=%b want 1/0", busy, wr_ready); end
      wait_tick(found, pre_sd, pre_pix);
      total++; if (!found) begin bad++; $display("FAIL ws_tick_timeout got=none want=frame_tick"); end
      total++; if (pre_sd || pre_pix) begin bad++; $display("FAIL ws_early_swap got sd=%b pix=%b want 0/0", pre_sd, pre_pix); end
      total++; if (swap_done !== 1'b1) begin bad++; $display("FAIL ws_swap_done got=%b want=1", swap_done); end
      @(negedge CLK); #1;
      total++; if (RedPixels[2][3] !== 1'b1 || GrnPixels[2][3] !== 1'b1) begin bad++; $display("FAIL ws_shown got r=%b g=%b want 1/1", RedPixels[2][3], GrnPixels[2][3]); end
      total++; if (busy !== 1'b0 || swap_done !== 1'b0) begin bad++; $display("FAIL ws_back_idle got busy=%b sd=%b want 0/0", busy, swap_done); end
   endtask

   task automatic test_clear_write;
      bit found, pre_sd, pre_pix;
      int bcnt;
      write_px(4'd5, 4'd7, 2'd1);
      write_px(4'd15, 4'd15, 2'd2);
      write_px(4'd0, 4'd0, 2'd3);
      @(negedge CLK);
      clr_req = 1'b1; wr_valid = 1'b1; wr_y = 4'd9; wr_x = 4'd9; wr_color = 2'd3;
      #1;
      total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL clr_wr_ready got=%b want=0", wr_ready); end
      @(negedge CLK);
      clr_req = 1'b0; wr_valid = 1'b0;
      bcnt = 0;
      for (int i = 0; i < 16; i++) begin
         #1;
         if (busy === 1'b1) bcnt++;
         @(negedge CLK);
      end
      #1;
      total++; if (bcnt != 16) begin bad++; $display("FAIL clr_busy_cycles got=%0d want=16", bcnt); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL clr_done_idle got=%b want=0", busy); end
      swap_req = 1'b1;
      @(negedge CLK);
      swap_req = 1'b0;
      wait_tick(found, pre_sd, pre_pix);
      total++; if (!found || swap_done !== 1'b1) begin bad++; $display("FAIL clr_swap got found=%b sd=%b want 1/1", found, swap_done); end
      @(negedge CLK); #1;
      total++; if (RedPixels !== '0 || GrnPixels !== '0) begin bad++; $display("FAIL clr_contents got=%h/%h want=0", RedPixels, GrnPixels); end
   endtask

   task automatic test_swap_during_clear;
      bit found, pre_sd, pre_pix;
      @(negedge CLK);
      clr_req = 1'b1;
      @(negedge CLK);
      clr_req = 1'b0;                 // row 0 in progress
      repeat (5) @(negedge CLK);
      swap_req = 1'b1;                // row 5 in progress
      @(negedge CLK);
      swap_req = 1'b0;
      repeat (9) @(negedge CLK);      // row 15 in progress
      #1;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL sdc_row15_busy got=%b want=1", busy); end
      @(negedge CLK); #1;
      total++; if (busy !== 1'b1 || wr_ready !== 1'b0) begin bad++; $display("FAIL sdc_swap_wait got busy=%b ready=%b want 1/0", busy, wr_ready); end
      wait_tick(found, pre_sd, pre_pix);
      total++; if (!found || swap_done !== 1'b1 || pre_sd) begin bad++; $display("FAIL sdc_swap got found=%b sd=%b early=%b want 1/1/0", found, swap_done, pre_sd); end
      @(negedge CLK); #1;
      total++; if (RedPixels !== '0 || GrnPixels !== '0 || busy !== 1'b0) begin bad++; $display("FAIL sdc_front got=%h/%h busy=%b want 0", RedPixels, GrnPixels, busy); end
   endtask

   task automatic test_halted_swap;
      logic [15:0][15:0] exp_g;
      exp_g = '0;
      exp_g[2][3] = 1'b1;
      write_px(4'd2, 4'd3, 2'd3);
      write_px(4'd2, 4'd3, 2'd2);     // overwrite: red must drop
      @(negedge CLK);
      run = 1'b0;
      repeat (2) @(negedge CLK);
      swap_req = 1'b1;
      #1;
      total++; if (EnableCount !== 1'b0 || swap_done !== 1'b0) begin bad++; $display("FAIL halt_pre got en=%b sd=%b want 0/0", EnableCount, swap_done); end
      @(negedge CLK);
      swap_req = 1'b0;
      #1;
      total++; if (swap_done !== 1'b1 || GrnPixels[2][3] !== 1'b0) begin bad++; $display("FAIL halt_swap_done got sd=%b g=%b want 1/0", swap_done, GrnPixels[2][3]); end
      @(negedge CLK); #1;
      total++; if (GrnPixels !== exp_g || RedPixels !== '0) begin bad++; $display("FAIL halt_front got r=%h g=%h want r=0 g=%h", RedPixels, GrnPixels, exp_g); end
      total++; if (busy !== 1'b0 || swap_done !== 1'b0) begin bad++; $display("FAIL halt_idle got busy=%b sd=%b want 0/0", busy, swap_done); end
   endtask

   task automatic test_reset_mid_swap;
      bit found, pre_sd, pre_pix;
      int sd_cnt;
      write_px(4'd7, 4'd1, 2'd1);
      @(negedge CLK);
      run = 1'b1;
      @(negedge CLK);
      wait_tick(found, pre_sd, pre_pix);
      total++; if (!found) begin bad++; $display("FAIL rms_tick_timeout got=none want=frame_tick"); end
      repeat (3) @(negedge CLK);
      swap_req = 1'b1;
      @(negedge CLK);
      swap_req = 1'b0;
      #1;
      total++; if (busy !== 1'b1 || swap_done !== 1'b0) begin bad++; $display("FAIL rms_waiting got busy=%b sd=%b want 1/0", busy, swap_done); end
      #1 RST_N = 1'b0;
      #1;
      total++; if (RedPixels !== '0 || GrnPixels !== '0) begin bad++; $display("FAIL rms_pixels got=%h/%h want=0", RedPixels, GrnPixels); end
      total++; if (EnableCount !== 1'b0 || busy !== 1'b0 || wr_ready !== 1'b0 || frame_tick !== 1'b0) begin bad++; $display("FAIL rms_outputs got en=%b busy=%b rdy=%b ft=%b want 0", EnableCount, busy, wr_ready, frame_tick); end
      sd_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         if (swap_done !== 1'b0) sd_cnt++;
         @(negedge CLK); #1;
      end
      total++; if (sd_cnt != 0) begin bad++; $display("FAIL rms_no_swap_done got=%0d want=0", sd_cnt); end
      run = 1'b0;
      RST_N = 1'b1;
      @(negedge CLK); #1;
      total++; if (RedPixels !== '0 || GrnPixels !== '0 || busy !== 1'b0 || swap_done !== 1'b0) begin bad++; $display("FAIL rms_after got=%h/%h busy=%b sd=%b want 0", RedPixels, GrnPixels, busy, swap_done); end
      swap_req = 1'b1;
      @(negedge CLK);
      swap_req = 1'b0;
      #1;
      total++; if (swap_done !== 1'b1) begin bad++; $display("FAIL rms_swap2 got=%b want=1", swap_done); end
      @(negedge CLK); #1;
      total++; if (RedPixels !== '0 || GrnPixels !== '0) begin bad++; $display("FAIL rms_back_cleared got=%h/%h want=0", RedPixels, GrnPixels); end
   endtask

   initial begin
      test_reset;
      test_scan;
      test_write_swap;
      test_clear_write;
      test_swap_during_clear;
      test_halted_swap;
      test_reset_mid_swap;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
